counter_reader: RTL and testbench
=================================

# counter_reader

Requester side of the counter read-back interface of the QoS PCIe block. On a `start` pulse it sweeps `idx` over all FIFO pop counters, asserting `req` and capturing `data_in` whenever the counter block returns `valid`. Captured values are held in a local register bank together with their sum. Sits between the test/control logic and the counter block: it drives `req`/`idx`, and the counter block answers combinationally when the system is `IDLE`.

## Interface
- `NUM_CNT`, 5, number of counters swept; idx runs 0..NUM_CNT-1 (max 8).
- `DATA_W`, 8, width of `data_in` and of each captured value.
- `TIMEOUT`, 16, max cycles spent on one idx without `valid` (1..255).

- `clk`  input  1  single clock, all logic on posedge.
- `reset_L`  input  1  reset, synchronous, active-low.
- `start`  input  1  begin sweep; sampled only in S_IDLE.
- `IDLE`  input  1  system idle status; monitored only, `valid` already reflects it.
- `valid`  input  1  counter block response valid (combinational on `req`/`idx`).
- `data_in`  input  DATA_W  counter value for current `idx`.
- `req`  output  1  read request, registered.
- `idx`  output  3  counter index being requested, registered.
- `cnt0`..`cnt4`  output  DATA_W each  captured counter values.
- `total`  output  DATA_W+3  sum of values captured in the current sweep.
- `busy`  output  1  high from the cycle after `start` until `done`, inclusive.
- `done`  output  1  one-cycle pulse when the sweep completes.
- `timeout_err`  output  1  sticky; set if any idx timed out; cleared on the next accepted `start`.

## Operation
- FSM states: S_IDLE, S_REQ, S_DONE.
- S_IDLE: `req`=0, `busy`=0. When `start`=1, go to S_REQ. On that transition: `idx`<=0, `total`<=0, `timeout_err`<=0, wait counter<=0.
- S_REQ: `req`=1, `busy`=1. Each cycle, sample `valid`:
  - `valid`=1: `cnt[idx]`<=`data_in`; `total`<=`total`+`data_in` (zero-extended, no overflow possible: 5×255=1275 < 2^11); wait counter<=0. If `idx`==NUM_CNT-1, go to S_DONE; otherwise `idx`<=`idx`+1.
  - `valid`=0 with wait counter < TIMEOUT-1: wait counter++; `idx`, `req` and `cnt` are held.
  - `valid`=0 with wait counter == TIMEOUT-1: `cnt[idx]`<=0; `timeout_err`<=1; advance exactly as for a capture, adding 0 to `total`.
- S_DONE: `req`=0, `done`=1, `busy`=1 for exactly one cycle, then return to S_IDLE. `idx` is held at NUM_CNT-1.
- `start` in S_REQ or S_DONE is ignored and not queued.
- `valid` outside S_REQ is ignored.
- `cnt*` and `total` keep their values after `done` until overwritten by the next sweep. `cnt*` keep stale values between sweeps until recaptured.
- Reset (any state, including mid-sweep): S_IDLE; `req`, `idx`, `cnt0`..`cnt4`, `total`, `busy`, `done`, `timeout_err` and the wait counter all 0.

## Timing
- `start` high in cycle t (state S_IDLE) gives `req`=1, `idx`=0 in cycle t+1.
- With `valid` continuously high: `idx`=k in cycle t+1+k, and `cnt[k]` updates on the edge ending that cycle.
- `done` is high in cycle t+NUM_CNT+1 (t+6 at default); `total` and all `cnt*` are final in that cycle.
- Each stall cycle (`valid`=0) adds 1 cycle of latency. A timed-out idx occupies exactly TIMEOUT cycles.
- Worst-case latency: NUM_CNT×TIMEOUT+1 cycles from `start` to `done`.
- Earliest next accepted `start`: cycle t+NUM_CNT+2, once back in S_IDLE.

## Test plan
- Reset: hold `reset_L`=0 for 2 cycles during a sweep -> next cycle all outputs 0, state S_IDLE; `valid` pulses are then ignored.
- Basic sweep: counter model holds 3,0,7,31,1 with `IDLE`=1, `start` at t -> `idx` 0..4 in t+1..t+5, `cnt0..4`=3,0,7,31,1, `total`=42, `done`=1 only at t+6, `timeout_err`=0.
- Stall: `IDLE`=0 for 4 cycles while `idx`=2 -> `idx` held at 2, `req` stays 1, no capture, `done` at t+10, values still correct.
- Timeout: `IDLE`=0 permanently, TIMEOUT=16 -> each idx held 16 cycles, `cnt*`=0, `total`=0, `timeout_err`=1, `done` at t+81. The next `start` clears `timeout_err`.
- Ignored start: pulse `start` at t+3 and in the `done` cycle -> single sweep, no restart, `busy` drops at t+7.
- Max values: all counters = 255 -> `total`=1275 with no truncation.

Source files
------------

// File: rtl/counter_reader.sv
// counter_reader: sweeps idx over the FIFO pop counters, captures each returned value
// into a local bank and accumulates their sum. A stalled idx gives up after TIMEOUT
// cycles, records 0 and raises a sticky timeout flag.
module counter_reader #(
  parameter int unsigned NUM_CNT = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_L,
  input  logic              i_start,
  input  logic              i_idle,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_req,
  output logic [2:0]        o_idx,
  output logic [DATA_W-1:0] o_cnt0,
  output logic [DATA_W-1:0] o_cnt1,
  output logic [DATA_W-1:0] o_cnt2,
  output logic [DATA_W-1:0] o_cnt3,
  output logic [DATA_W-1:0] o_cnt4,
  output logic [DATA_W+2:0] o_total,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout_err
);

  // Bank is sized for the largest legal sweep; only the first five are exported.
  localparam int unsigned BankSize = 8;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            r_state;
  logic              r_req;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_cnt [BankSize];
  logic [DATA_W+2:0] r_total;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout_err;
  logic [7:0]        r_wait;

  logic              w_expired;
  logic              w_advance;
  logic              w_last;
  logic [DATA_W-1:0] w_cap_val;
  logic              w_unused_idle;

  // IDLE is already folded into valid by the counter block; kept on the port for visibility.
  assign w_unused_idle = i_idle;

  // Decide whether the current idx is finished this cycle and what it contributes.
  always_comb begin
    w_expired = (r_wait == 8'(TIMEOUT - 1));
    w_advance = i_valid || w_expired;
    w_last    = (r_idx == 3'(NUM_CNT - 1));
    w_cap_val = i_valid ? i_data_in : '0;
  end

  // Sweep FSM with registered req/busy/done and the capture bank.
  always_ff @(posedge i_clk) begin
    if (!i_reset_L) begin
      r_state       <= StIdle;
      r_req         <= 1'b0;
      r_idx         <= '0;
      r_total       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wait        <= '0;
      for (int i = 0; i < BankSize; i++) r_cnt[i] <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state       <= StReq;
            r_req         <= 1'b1;
            r_busy        <= 1'b1;
            r_idx         <= '0;
            r_total       <= '0;
            r_timeout_err <= 1'b0;
            r_wait        <= '0;
          end
        end
        StReq: begin
          if (w_advance) begin
            r_cnt[r_idx] <= w_cap_val;
            r_total      <= r_total + {3'b000, w_cap_val};
            r_wait       <= '0;
            if (!i_valid) r_timeout_err <= 1'b1;
            if (w_last) begin
              r_state <= StDone;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req         = r_req;
  assign o_idx         = r_idx;
  assign o_cnt0        = r_cnt[0];
  assign o_cnt1        = r_cnt[1];
  assign o_cnt2        = r_cnt[2];
  assign o_cnt3        = r_cnt[3];
  assign o_cnt4        = r_cnt[4];
  assign o_total       = r_total;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_counter_reader.sv
// Bench for counter_reader: emulates the counter block, precomputes each sweep's
// timeline from the memory contents and the IDLE pattern, and compares every cycle.
module tb_counter_reader;

  localparam int NC = 5;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       start;
  logic       idle;
  logic       valid;
  logic [7:0] data_in;
  logic       req;
  logic [2:0] idx;
  logic [7:0] cnt0, cnt1, cnt2, cnt3, cnt4;
  logic [10:0] total;
  logic       busy, done, terr;

  logic       stray;
  logic [7:0] stray_data;
  logic [7:0] mem [8];

  int n_total = 0;
  int n_bad = 0;

  // Expected values carried over from the previous sweep.
  int exp_cnt [NC];
  int exp_total, exp_terr, exp_idx;

  bit idle_pat [256];

  always #5 clk = ~clk;

  // Counter block: answers combinationally while req is high; random noise otherwise.
  always_comb begin
    valid   = req ? idle : stray;
    data_in = req ? mem[idx] : stray_data;
  end

  counter_reader #(.NUM_CNT(NC), .DATA_W(8), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_reset_L    (reset_l),
    .i_start      (start),
    .i_idle       (idle),
    .i_valid      (valid),
    .i_data_in    (data_in),
    .o_req        (req),
    .o_idx        (idx),
    .o_cnt0       (cnt0),
    .o_cnt1       (cnt1),
    .o_cnt2       (cnt2),
    .o_cnt3       (cnt3),
    .o_cnt4       (cnt4),
    .o_total      (total),
    .o_busy       (busy),
    .o_done       (done),
    .o_timeout_err(terr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  function automatic int cnt_of(input int k);
    case (k)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      3: return int'(cnt3);
      default: return int'(cnt4);
    endcase
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " req"}, int'(req), 0);
    chk({tag, " idx"}, int'(idx), 0);
    for (int k = 0; k < NC; k++) chk($sformatf("%s cnt%0d", tag, k), cnt_of(k), 0);
    chk({tag, " total"}, int'(total), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " terr"}, int'(terr), 0);
  endtask

  // One sweep: offset 0 is the cycle start is high. Timeline derived per idx:
  // it lasts until the first idle cycle (inclusive) or TO cycles, whichever is first.
  task automatic sweep(input string tag, input bit xs3, input bit xs_done, input bit rnd_starts,
                       input int gap, input int lit_total, input int lit_done);
    int s [NC];
    int e [NC];
    int cap [NC];
    int tmo [NC];
    int pos, d, done_off, seen, k_cur, sum, any_to;
    bit found, st;
    pos = 1;
    for (int k = 0; k < NC; k++) begin
      found = 0;
      d = TO;
      for (int j = 0; j < TO; j++)
        if (!found && idle_pat[pos+j]) begin
          found = 1;
          d = j + 1;
        end
      s[k] = pos;
      e[k] = pos + d;
      cap[k] = found ? int'(mem[k]) : 0;
      tmo[k] = found ? 0 : 1;
      pos = e[k];
    end
    done_off = pos;
    seen = -1;
    for (int c = 0; c <= done_off + gap; c++) begin
      @(negedge clk);
      if (done && seen < 0) seen = c;
      k_cur = NC - 1;
      for (int k = 0; k < NC; k++) if (c >= s[k] && c < e[k]) k_cur = k;
      sum = 0;
      any_to = 0;
      for (int k = 0; k < NC; k++)
        if (c >= e[k]) begin
          sum += cap[k];
          any_to |= tmo[k];
        end
      chk($sformatf("%s req c%0d", tag, c), int'(req), int'(c >= 1 && c < done_off));
      chk($sformatf("%s idx c%0d", tag, c), int'(idx), (c == 0) ? exp_idx : k_cur);
      chk($sformatf("%s busy c%0d", tag, c), int'(busy), int'(c >= 1 && c <= done_off));
      chk($sformatf("%s done c%0d", tag, c), int'(done), int'(c == done_off));
      chk($sformatf("%s total c%0d", tag, c), int'(total), (c == 0) ? exp_total : sum);
      chk($sformatf("%s terr c%0d", tag, c), int'(terr), (c == 0) ? exp_terr : any_to);
      for (int k = 0; k < NC; k++)
        chk($sformatf("%s cnt%0d c%0d", tag, k, c), cnt_of(k),
            (c >= 1 && c >= e[k]) ? cap[k] : exp_cnt[k]);
      if (c == done_off && lit_total >= 0) chk({tag, " lit_total"}, int'(total), lit_total);
      st = (c == 0) || (xs3 && c == 3) || (xs_done && c == done_off) ||
           (rnd_starts && c >= 1 && c <= done_off && $urandom_range(0, 2) == 0);
      start      = st;
      idle       = idle_pat[c];
      stray      = 1'($urandom_range(0, 1));
      stray_data = 8'($urandom_range(0, 255));
    end
    start = 1'b0;
    if (lit_done >= 0) chk({tag, " lit_done"}, seen, lit_done);
    for (int k = 0; k < NC; k++) exp_cnt[k] = cap[k];
    exp_total = sum;
    exp_terr  = any_to;
    exp_idx   = NC - 1;
  endtask

  task automatic set_mem(input int a, input int b, input int c, input int d, input int f);
    mem[0] = 8'(a); mem[1] = 8'(b); mem[2] = 8'(c); mem[3] = 8'(d); mem[4] = 8'(f);
  endtask

  task automatic pat_fill(input bit v);
    for (int i = 0; i < 256; i++) idle_pat[i] = v;
  endtask

  initial begin
    reset_l = 1'b0;
    start = 1'b0;
    idle = 1'b1;
    stray = 1'b0;
    stray_data = '0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 10);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    check_zero("reset");

    // Mid-sweep reset held 2 cycles, then stray valids must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    check_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      stray = 1'b1;
      stray_data = 8'hA5;
      @(negedge clk);
      check_zero($sformatf("stray%0d", i));
    end
    stray = 1'b0;
    for (int k = 0; k < NC; k++) exp_cnt[k] = 0;
    exp_total = 0;
    exp_terr = 0;
    exp_idx = 0;

    // Basic sweep.
    set_mem(3, 0, 7, 31, 1);
    pat_fill(1'b1);
    sweep("basic", 0, 0, 0, 2, 42, 6);

    // Stall: idx 2 starts at offset 3; 4 idle-low cycles push done to 10.
    for (int i = 3; i < 7; i++) idle_pat[i] = 1'b0;
    sweep("stall", 0, 0, 0, 2, 42, 10);

    // Timeout on every idx.
    pat_fill(1'b0);
    sweep("tmo", 0, 0, 0, 2, 0, 81);

    // Ignored starts mid-sweep and in the done cycle; also clears timeout_err.
    set_mem(9, 8, 7, 6, 5);
    pat_fill(1'b1);
    sweep("ign", 1, 1, 0, 3, 35, 6);

    // Max values.
    set_mem(255, 255, 255, 255, 255);
    sweep("max", 0, 0, 0, 2, 1275, 6);

    // Randomized sweeps.
    for (int n = 0; n < 20; n++) begin
      int w;
      for (int i = 0; i < NC; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) idle_pat[i] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(1, 40);
        for (int i = w; i < w + 20; i++) idle_pat[i] = 1'b0;
      end
      sweep($sformatf("rnd%0d", n), 0, 0, 1, $urandom_range(1, 3), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
